// File: rtl/imem_arb_if.sv
// Bus bundle for the instruction-memory arbiter: fetch port, debug port and memory side.
// The arbiter takes the slave view; the surrounding requesters and memory take the master view.
interface imem_arb_if #(
  parameter int AW = 6,
  parameter int DW = 32
);
  logic          fetch_req;
  logic [AW-1:0] fetch_adr;
  logic          fetch_gnt;
  logic          fetch_valid;
  logic [DW-1:0] fetch_rd;
  logic          dbg_req;
  logic [AW-1:0] dbg_adr;
  logic          dbg_gnt;
  logic          dbg_valid;
  logic [DW-1:0] dbg_rd;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_rd;

  modport slave (
    input  fetch_req, fetch_adr, dbg_req, dbg_adr, mem_rd,
    output fetch_gnt, fetch_valid, fetch_rd, dbg_gnt, dbg_valid, dbg_rd, mem_a
  );

  modport master (
    output fetch_req, fetch_adr, dbg_req, dbg_adr, mem_rd,
    input  fetch_gnt, fetch_valid, fetch_rd, dbg_gnt, dbg_valid, dbg_rd, mem_a
  );
endinterface

// File: rtl/imem_arb.sv
// Arbiter sharing a single-ported, combinationally-read instruction memory between fetch and debug.
// Fetch has fixed priority; a starvation counter forces one debug grant after MAXWAIT denied cycles.
module imem_arb #(
  parameter int AW      = 6,
  parameter int DW      = 32,
  parameter int MAXWAIT = 4
) (
  input  logic       clk,
  input  logic       reset_b,
  imem_arb_if.slave  bus
);

  typedef enum logic {
    NORMAL    = 1'b0,
    FORCE_DBG = 1'b1
  } mode_t;

  localparam logic [3:0] MAXW = 4'(MAXWAIT);

  mode_t         mode_s;
  logic          force_s;
  logic          fetch_gnt_s;
  logic          dbg_gnt_s;
  logic [AW-1:0] mem_a_s;
  logic [3:0]    wait_cnt_r;
  logic          fetch_valid_r;
  logic          dbg_valid_r;
  logic [DW-1:0] fetch_rd_r;
  logic [DW-1:0] dbg_rd_r;

  // Arbitration mode, grants and memory address select
  always_comb begin
    force_s     = bus.dbg_req & (wait_cnt_r == MAXW);
    mode_s      = force_s ? FORCE_DBG : NORMAL;
    fetch_gnt_s = 1'b0;
    dbg_gnt_s   = 1'b0;
    mem_a_s     = bus.fetch_adr;
    if (!reset_b) begin
      fetch_gnt_s = 1'b0;
      dbg_gnt_s   = 1'b0;
    end else begin
      case (mode_s)
        NORMAL: begin
          fetch_gnt_s = bus.fetch_req;
          dbg_gnt_s   = bus.dbg_req & ~bus.fetch_req;
        end
        FORCE_DBG: begin
          fetch_gnt_s = 1'b0;
          dbg_gnt_s   = 1'b1;
        end
        default: begin
          fetch_gnt_s = 1'b0;
          dbg_gnt_s   = 1'b0;
        end
      endcase
    end
    // An ungranted cycle still presents fetch_adr; that read is simply discarded.
    if (dbg_gnt_s) begin
      mem_a_s = bus.dbg_adr;
    end else begin
      mem_a_s = bus.fetch_adr;
    end
  end

  // Starvation counter: counts consecutive denied debug cycles, saturating at MAXWAIT
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wait_cnt_r <= 4'd0;
    end else if (dbg_gnt_s || !bus.dbg_req) begin
      wait_cnt_r <= 4'd0;
    end else if (wait_cnt_r != MAXW) begin
      wait_cnt_r <= wait_cnt_r + 4'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Return path: one-cycle registered read data and valid per requester
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      fetch_valid_r <= 1'b0;
      dbg_valid_r   <= 1'b0;
      fetch_rd_r    <= '0;
      dbg_rd_r      <= '0;
    end else begin
      fetch_valid_r <= fetch_gnt_s;
      dbg_valid_r   <= dbg_gnt_s;
      if (fetch_gnt_s) begin
        fetch_rd_r <= bus.mem_rd;
      end else begin
        fetch_rd_r <= fetch_rd_r;
      end
      if (dbg_gnt_s) begin
        dbg_rd_r <= bus.mem_rd;
      end else begin
        dbg_rd_r <= dbg_rd_r;
      end
    end
  end

  assign bus.fetch_gnt   = fetch_gnt_s;
  assign bus.dbg_gnt     = dbg_gnt_s;
  assign bus.mem_a       = mem_a_s;
  assign bus.fetch_valid = fetch_valid_r;
  assign bus.dbg_valid   = dbg_valid_r;
  assign bus.fetch_rd    = fetch_rd_r;
  assign bus.dbg_rd      = dbg_rd_r;

endmodule

// File: doc/imem_arb.md
# imem_arb

Two-requester arbiter sharing the single-ported, combinationally-read instruction memory (64 x 32-bit words, word address) between the processor fetch unit and the debug/test read port. It grants one requester per cycle and drives the memory address. It registers the read word back to the granted requester one cycle later. A starvation counter guarantees the debug port a slot even while fetch requests continuously.

## Interface
- AW, 6, word-address width (matches 64-word instruction memory)
- DW, 32, data width
- MAXWAIT, 4, consecutive denied debug cycles before debug is forced a grant (legal range 1..15)

- clk  input  1  clock; all state updates on rising edge
- reset_b  input  1  asynchronous, active-low reset
- fetch_req  input  1  fetch requests a read this cycle; fetch_adr must be held stable until fetch_gnt
- fetch_adr  input  AW  fetch word address
- fetch_gnt  output  1  fetch request accepted this cycle (combinational)
- fetch_valid  output  1  fetch_rd holds the word for the request granted last cycle
- fetch_rd  output  DW  registered read data to fetch
- dbg_req  input  1  debug requests a read; dbg_adr held until dbg_gnt
- dbg_adr  input  AW  debug word address
- dbg_gnt  output  1  debug request accepted this cycle (combinational)
- dbg_valid  output  1  dbg_rd valid for the request granted last cycle
- dbg_rd  output  DW  registered read data to debug
- mem_a  output  AW  address to instruction memory
- mem_rd  input  DW  instruction memory read data (combinational from mem_a)

## Operation
- Internal starvation counter `wait_cnt`, 4 bits, saturating at MAXWAIT.
- Two arbitration modes, selected by `force = dbg_req & (wait_cnt == MAXWAIT)`:
  - NORMAL (force=0): fetch has fixed priority.
  - FORCE_DBG (force=1): debug wins for exactly one cycle.
- Grant equations, both forced 0 while reset_b=0:
  - fetch_gnt = fetch_req & ~force.
  - dbg_gnt = dbg_req & ~fetch_gnt.
  - At most one grant is high in any cycle.
- mem_a = dbg_adr when dbg_gnt, else fetch_adr. When neither is granted, mem_a = fetch_adr; the read is harmless and discarded.
- wait_cnt update:
  - Cleared to 0 when dbg_gnt or ~dbg_req.
  - Otherwise incremented, saturating at MAXWAIT.
- Return path, per requester X:
  - X_valid <= X_gnt.
  - X_rd <= mem_rd when X_gnt; otherwise X_rd holds its previous value.
- Requesters may keep req high across consecutive cycles. Each granted cycle is one independent read, so fetch can stream back-to-back at one word per cycle.
- Dropping req before its grant is legal: that request is abandoned and no valid follows. If dbg_req drops this way, wait_cnt clears.
- Address is not checked; it wraps naturally modulo 2^AW.

## Timing
- Reset (reset_b low, asynchronous):
  - fetch_valid=0, dbg_valid=0, fetch_rd=0, dbg_rd=0, wait_cnt=0.
  - Grants are held 0.
- Reset asserted mid-operation clears all state immediately. A request granted in the cycle reset asserts produces no valid.
- Read latency: grant in cycle N, then X_valid=1 and X_rd=RAM[adr] during cycle N+1 (after edge N).
- Continuous fetch_req and dbg_req from cycle 0, with MAXWAIT=M:
  - Fetch is granted cycles 0..M-1.
  - Debug is granted cycle M, and fetch is denied that cycle.
  - The pattern then repeats.
  - Debug is therefore served at least once every M+1 cycles.
- Simultaneous first requests with wait_cnt=0: fetch wins.
- dbg_req alone: dbg_gnt in the same cycle, zero wait.
- No other latency or pipeline stages.

## Test plan
- Reset, then fetch_req=1 with fetch_adr=0,1,2,3 on consecutive cycles, dbg_req=0 -> fetch_gnt high all 4 cycles. fetch_valid high cycles 1..4 with fetch_rd=RAM[0..3]. dbg_valid stays 0.
- dbg_req=1, dbg_adr=0x3F alone -> dbg_gnt same cycle, mem_a=0x3F. Next cycle dbg_valid=1 and dbg_rd=RAM[63]. dbg_rd holds that value afterward while dbg_valid=0.
- Both req held high for 12 cycles, MAXWAIT=4 -> dbg_gnt exactly in cycles 4 and 9, fetch_gnt in all other cycles. Never both grants high.
- dbg_req high for 2 cycles (denied), then low for 1 cycle, then high again with fetch_req continuous -> wait_cnt restarts from 0. First debug grant comes 4 cycles after re-assertion.
- reset_b pulsed low asynchronously mid-cycle right after a grant -> valids and rd drop to 0 immediately with no clock. No valid appears after release until a new grant.
- mem_rd driven X while no grant for several cycles -> fetch_rd and dbg_rd unchanged, valids 0.
